// File: rtl/tournament_selector_if.sv
// tournament_selector_if: population and fitness-evaluator bus.
// master = selector side, slave = population/evaluator side.
interface tournament_selector_if #(
  parameter int Width        = 32,
  parameter int FitnessWidth = 16
);

  logic                    ce;
  logic [Width-1:0]        individual;
  logic                    we;
  logic [Width-1:0]        winner;
  logic                    fit_req;
  logic [Width-1:0]        fit_individual;
  logic                    fit_ack;
  logic [FitnessWidth-1:0] fitness;

  modport master (
    output ce,
    output we,
    output winner,
    output fit_req,
    output fit_individual,
    input  individual,
    input  fit_ack,
    input  fitness
  );

  modport slave (
    input  ce,
    input  we,
    input  winner,
    input  fit_req,
    input  fit_individual,
    output individual,
    output fit_ack,
    output fitness
  );

endinterface

// File: rtl/tournament_selector.sv
// tournament_selector: one compact-GA tournament per generation.
// Samples A/B, evaluates both, emits the fitter and tracks the best.
module tournament_selector #(
  parameter int Width          = 32,
  parameter int FitnessWidth   = 16,
  parameter int GenWidth       = 16,
  parameter int MaxGenerations = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  tournament_selector_if.master   bus,
  output logic [Width-1:0]        best,
  output logic [FitnessWidth-1:0] best_fitness,
  output logic [GenWidth-1:0]     generation,
  output logic                    busy,
  output logic                    done
);

  localparam logic [GenWidth-1:0] GenMax =
    GenWidth'(MaxGenerations);

  typedef enum logic [3:0] {
    IDLE,
    SMP_A,
    CAP_A,
    EVAL_A,
    SMP_B,
    CAP_B,
    EVAL_B,
    UPDATE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [Width-1:0]        reg_a;
  logic [Width-1:0]        reg_b;
  logic [Width-1:0]        winner_q;
  logic [FitnessWidth-1:0] fit_a;
  logic                    best_valid;

  logic ce;
  logic we;
  logic fit_req;

  logic                    b_wins;
  logic [Width-1:0]        win_ind;
  logic [FitnessWidth-1:0] win_fit;
  logic                    run_start;
  logic                    eval_b_ack;

  // B must be strictly fitter; a tie keeps A.
  assign b_wins  = bus.fitness > fit_a;
  assign win_ind = b_wins ? reg_b : reg_a;
  assign win_fit = b_wins ? bus.fitness : fit_a;

  assign run_start  = start &&
                      (state == IDLE || state == DONE);
  assign eval_b_ack = (state == EVAL_B) && bus.fit_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and one-cycle strobes
  always_comb begin
    state_n = state;
    ce      = 1'b0;
    we      = 1'b0;
    fit_req = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) state_n = SMP_A;
      end
      SMP_A: begin
        ce      = 1'b1;
        state_n = CAP_A;
      end
      CAP_A: state_n = EVAL_A;
      EVAL_A: begin
        fit_req = 1'b1;
        if (bus.fit_ack) state_n = SMP_B;
      end
      SMP_B: begin
        ce      = 1'b1;
        state_n = CAP_B;
      end
      CAP_B: state_n = EVAL_B;
      EVAL_B: begin
        fit_req = 1'b1;
        if (bus.fit_ack) state_n = UPDATE;
      end
      UPDATE: begin
        we      = 1'b1;
        state_n = (generation == GenMax) ? DONE : SMP_A;
      end
      default: state_n = IDLE;
    endcase
  end

  // Samples, fitness, winner and best-so-far; the generation's
  // results are registered on B's ack so they show with we.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_a        <= '0;
      reg_b        <= '0;
      fit_a        <= '0;
      winner_q     <= '0;
      best         <= '0;
      best_fitness <= '0;
      best_valid   <= 1'b0;
      generation   <= '0;
    end else begin
      if (run_start) begin
        generation   <= '0;
        best         <= '0;
        best_fitness <= '0;
        best_valid   <= 1'b0;
      end
      if (state == CAP_A) reg_a <= bus.individual;
      if (state == CAP_B) reg_b <= bus.individual;
      if (state == EVAL_A && bus.fit_ack) begin
        fit_a <= bus.fitness;
      end
      if (eval_b_ack) begin
        winner_q <= win_ind;
        if (generation != GenMax) begin
          generation <= generation + GenWidth'(1);
        end
        if (!best_valid || win_fit > best_fitness) begin
          best         <= win_ind;
          best_fitness <= win_fit;
          best_valid   <= 1'b1;
        end
      end
    end
  end

  assign bus.ce      = ce;
  assign bus.we      = we;
  assign bus.fit_req = fit_req;
  assign bus.winner  = winner_q;

  assign bus.fit_individual =
    (state == EVAL_A) ? reg_a :
    (state == EVAL_B) ? reg_b : '0;

  assign busy = !(state == IDLE || state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_tournament_selector.sv
// tb_tournament_selector: randomized bench with reference model.
// Three instances: main (8 gens), single-gen, and 8-bit onemax run.
module tb_tournament_selector;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic [31:0] best0;
  logic [31:0] best1;
  logic [7:0]  best2;
  logic [15:0] bf0, bf1, bf2;
  logic [15:0] gen0, gen1, gen2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;

  tournament_selector_if #(.Width(32), .FitnessWidth(16)) b0 ();
  tournament_selector_if #(.Width(32), .FitnessWidth(16)) b1 ();
  tournament_selector_if #(.Width(8),  .FitnessWidth(16)) b2 ();

  tournament_selector #(
    .Width(32), .FitnessWidth(16),
    .GenWidth(16), .MaxGenerations(8)
  ) u0 (
    .clk(clk), .rst(rst), .start(start0), .bus(b0),
    .best(best0), .best_fitness(bf0), .generation(gen0),
    .busy(busy0), .done(done0)
  );

  tournament_selector #(
    .Width(32), .FitnessWidth(16),
    .GenWidth(16), .MaxGenerations(1)
  ) u1 (
    .clk(clk), .rst(rst), .start(start1), .bus(b1),
    .best(best1), .best_fitness(bf1), .generation(gen1),
    .busy(busy1), .done(done1)
  );

  tournament_selector #(
    .Width(8), .FitnessWidth(16),
    .GenWidth(16), .MaxGenerations(200)
  ) u2 (
    .clk(clk), .rst(rst), .start(start2), .bus(b2),
    .best(best2), .best_fitness(bf2), .generation(gen2),
    .busy(busy2), .done(done2)
  );

  // Evaluator 0: fitness is the upper half-word, delay dly0.
  int   dly0 = 0;
  int   cnt0 = 0;
  logic stray0 = 1'b0;
  always @(negedge clk) begin
    b0.fit_ack = stray0;
    if (!b0.fit_req) cnt0 = 0;
    else if (cnt0 >= dly0) begin
      b0.fit_ack = 1'b1;
      b0.fitness = b0.fit_individual[31:16];
      cnt0 = 0;
    end else cnt0++;
  end

  // Evaluator 1: popcount, acks after 3 waiting cycles.
  int cnt1 = 0;
  always @(negedge clk) begin
    b1.fit_ack = 1'b0;
    if (!b1.fit_req) cnt1 = 0;
    else if (cnt1 >= 3) begin
      b1.fit_ack = 1'b1;
      b1.fitness = 16'($countones(b1.fit_individual));
      cnt1 = 0;
    end else cnt1++;
  end

  // Evaluator 2: onemax with random 0..2 cycle delay.
  int cnt2 = 0;
  int dly2 = 1;
  always @(negedge clk) begin
    b2.fit_ack = 1'b0;
    if (!b2.fit_req) cnt2 = 0;
    else if (cnt2 >= dly2) begin
      b2.fit_ack = 1'b1;
      b2.fitness = 16'($countones(b2.fit_individual));
      cnt2 = 0;
      dly2 = int'($urandom_range(2, 0));
    end else cnt2++;
  end

  // Population 2: compact-GA probability vector, scale 0..32.
  int         p2 [8];
  logic [7:0] s2a, s2b, smp2, lose2;
  bit         s2sel;
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) p2[i] = 16;
      s2sel = 1'b0;
    end else begin
      if (b2.ce) begin
        for (int i = 0; i < 8; i++)
          smp2[i] = int'($urandom_range(31, 0)) < p2[i];
        b2.individual = smp2;
        if (!s2sel) s2a = smp2;
        else        s2b = smp2;
        s2sel = !s2sel;
      end
      if (b2.we && s2a != s2b) begin
        lose2 = (b2.winner == s2a) ? s2b : s2a;
        for (int i = 0; i < 8; i++) begin
          if (b2.winner[i] != lose2[i]) begin
            p2[i] += b2.winner[i] ? 1 : -1;
            if (p2[i] > 32) p2[i] = 32;
            if (p2[i] < 0)  p2[i] = 0;
          end
        end
      end
    end
  end

  // Reference model for instance 0 (fitness = upper half-word).
  logic        m_valid;
  logic [31:0] m_best;
  logic [15:0] m_bf;
  logic [15:0] m_gen;

  function automatic void model_start();
    m_valid = 1'b0;
    m_best  = '0;
    m_bf    = '0;
    m_gen   = '0;
  endfunction

  function automatic logic [31:0] model_gen(
    input logic [31:0] a, input logic [31:0] b);
    logic [15:0] fa = a[31:16];
    logic [15:0] fb = b[31:16];
    logic [31:0] w  = (fb > fa) ? b : a;
    logic [15:0] wf = (fb > fa) ? fb : fa;
    if (!m_valid || wf > m_bf) begin
      m_best  = w;
      m_bf    = wf;
      m_valid = 1'b1;
    end
    m_gen++;
    return w;
  endfunction

  // One generation on instance 0: feeds a/b on ce, returns at we.
  logic [31:0] w0;
  int          ces0, cyc0, req0;
  bit          to0, unstable0;
  task automatic run0(input logic [31:0] a,
                      input logic [31:0] b,
                      input bit first);
    logic [31:0] pfi = '0;
    bit          preq = 1'b0;
    ces0 = 0; cyc0 = 0; req0 = 0;
    to0 = 1'b1; unstable0 = 1'b0;
    if (first) start0 = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (first) start0 = 1'b0;
      cyc0++;
      if (b0.ce) begin
        ces0++;
        b0.individual = (ces0 == 1) ? a : b;
      end
      if (b0.fit_req) begin
        req0++;
        if (preq && b0.fit_individual !== pfi)
          unstable0 = 1'b1;
      end
      preq = b0.fit_req;
      pfi  = b0.fit_individual;
      if (b0.we) begin
        w0  = b0.winner;
        to0 = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] st;
    do_reset(2);
    st = {b0.ce, b0.we, b0.fit_req, busy0, done0};
    n_checks++;
    if (st !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b want 0", st);
    end
    n_checks++;
    if ({best0, bf0, gen0} !== 64'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h/%h/%h want 0",
               best0, bf0, gen0);
    end
    dly0 = 50;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    b0.individual = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      st = {b0.ce, b0.we, b0.fit_req, busy0, done0};
      n_checks++;
      if (st !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_midrun_%0d: got %b want 0", i, st);
      end
    end
    rst = 1'b0;
    n_checks++;
    if ({b0.fit_individual, b0.winner} !== 64'b0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h/%h want 0",
               b0.fit_individual, b0.winner);
    end
    st = {busy1, done1, busy2, done2, b2.we};
    n_checks++;
    if (st !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_others: got %b want 0", st);
    end
    dly0 = 0;
  endtask

  task automatic test_single_generation();
    bit          seen = 1'b0;
    int          nce = 0;
    logic [31:0] w;
    do_reset(1);
    start1 = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (b1.ce) begin
        nce++;
        b1.individual = (nce == 1) ? 32'h0000_00FF
                                   : 32'hFFFF_0000;
      end
      if (b1.we) seen = 1'b1;
    end
    w = b1.winner;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL single_we: got no we want pulse");
    end
    n_checks++;
    if (w !== 32'hFFFF_0000) begin
      n_fail++;
      $display("FAIL single_winner: got %h want ffff0000", w);
    end
    n_checks++;
    if (best1 !== 32'hFFFF_0000 || bf1 !== 16'd16) begin
      n_fail++;
      $display("FAIL single_best: got %h/%0d want ffff0000/16",
               best1, bf1);
    end
    n_checks++;
    if (gen1 !== 16'd1 || nce != 2) begin
      n_fail++;
      $display("FAIL single_gen: got %0d/%0d want 1/2",
               gen1, nce);
    end
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b1 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got %b%b want 10",
               done1, busy1);
    end
    n_checks++;
    if (b1.winner !== w || b1.we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got %h/%b want %h/0",
               b1.winner, b1.we, w);
    end
  endtask

  task automatic test_tie_zero();
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] exp;
    av = '{32'h0000_1111, 32'h0000_3333,
           32'h0005_AAAA, 32'h0005_CCCC};
    bv = '{32'h0000_2222, 32'h0000_4444,
           32'h0005_BBBB, 32'h0005_DDDD};
    do_reset(1);
    model_start();
    dly0 = 0;
    for (int g = 0; g < 4; g++) begin
      run0(av[g], bv[g], g == 0);
      exp = model_gen(av[g], bv[g]);
      n_checks++;
      if (to0 || w0 !== exp) begin
        n_fail++;
        $display("FAIL tie_winner_%0d: got %h want %h",
                 g, w0, exp);
      end
      n_checks++;
      if (best0 !== m_best || bf0 !== m_bf) begin
        n_fail++;
        $display("FAIL tie_best_%0d: got %h/%0d want %h/%0d",
                 g, best0, bf0, m_best, m_bf);
      end
    end
    n_checks++;
    if (best0 !== 32'h0005_AAAA) begin
      n_fail++;
      $display("FAIL tie_final: got %h want 0005aaaa", best0);
    end
  endtask

  task automatic test_handshake();
    bit          bad = 1'b0;
    logic [31:0] a = {16'd9, 16'($urandom)};
    logic [31:0] b = {16'd4, 16'($urandom)};
    logic [31:0] exp;
    do_reset(1);
    model_start();
    @(negedge clk);
    stray0 = 1'b1;
    @(negedge clk);
    stray0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (busy0 || b0.ce || b0.fit_req || b0.we) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL stray_ack: got activity want idle");
    end
    dly0 = 20;
    run0(a, b, 1'b1);
    exp = model_gen(a, b);
    n_checks++;
    if (to0 || w0 !== exp) begin
      n_fail++;
      $display("FAIL slow_winner: got %h want %h", w0, exp);
    end
    n_checks++;
    if (ces0 != 2 || req0 != 42) begin
      n_fail++;
      $display("FAIL slow_counts: got ce=%0d req=%0d want 2/42",
               ces0, req0);
    end
    n_checks++;
    if (unstable0) begin
      n_fail++;
      $display("FAIL slow_stable: got changing fit_individual");
    end
    dly0 = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, exp;
    do_reset(1);
    model_start();
    dly0 = 0;
    for (int g = 0; g < 4; g++) begin
      a = $urandom;
      b = $urandom;
      if (g == 3) start0 = 1'b1;
      run0(a, b, g == 0);
      start0 = 1'b0;
      exp = model_gen(a, b);
      n_checks++;
      if (to0 || w0 !== exp || gen0 !== m_gen) begin
        n_fail++;
        $display("FAIL b2b_gen_%0d: got %h/%0d want %h/%0d",
                 g, w0, gen0, exp, m_gen);
      end
      if (g > 0) begin
        n_checks++;
        if (cyc0 != 7 || ces0 != 2) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: got %0d/%0d want 7/2",
                   g, cyc0, ces0);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit          hit = 1'b0;
    bit          act = 1'b0;
    int          n = 0;
    logic [31:0] exp;
    logic [5:0]  st;
    do_reset(1);
    model_start();
    dly0 = 0;
    run0(32'h0003_0001, 32'h0001_0002, 1'b1);
    dly0 = 30;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (b0.ce) begin
        n++;
        b0.individual = (n == 1) ? 32'h0007_1111
                                 : 32'h0009_2222;
      end
      if (b0.fit_req && b0.fit_individual === 32'h0009_2222)
        hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL abort_reach: got no EVAL_B want EVAL_B");
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    st = {b0.ce, b0.we, b0.fit_req, busy0, done0,
          |b0.fit_individual};
    n_checks++;
    if (st !== 6'b0) begin
      n_fail++;
      $display("FAIL abort_idle: got %b want 0", st);
    end
    n_checks++;
    if ({gen0, best0, bf0} !== 64'b0) begin
      n_fail++;
      $display("FAIL abort_regs: got %0d/%h/%0d want 0",
               gen0, best0, bf0);
    end
    dly0 = 0;
    repeat (5) begin
      @(negedge clk);
      if (b0.we || b0.ce || busy0) act = 1'b1;
    end
    n_checks++;
    if (act) begin
      n_fail++;
      $display("FAIL abort_quiet: got activity want none");
    end
    model_start();
    run0(32'h0002_5555, 32'h0006_6666, 1'b1);
    exp = model_gen(32'h0002_5555, 32'h0006_6666);
    n_checks++;
    if (to0 || gen0 !== 16'd1 || w0 !== exp) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d/%h want 1/%h",
               gen0, w0, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp;
    for (int r = 0; r < 3; r++) begin
      do_reset(1);
      model_start();
      for (int g = 0; g < 8; g++) begin
        a = {16'($urandom_range(6, 0)), 16'($urandom)};
        b = {16'($urandom_range(6, 0)), 16'($urandom)};
        dly0 = int'($urandom_range(3, 0));
        run0(a, b, g == 0);
        exp = model_gen(a, b);
        n_checks++;
        if (to0 || w0 !== exp) begin
          n_fail++;
          $display("FAIL rnd_winner_%0d_%0d: got %h want %h",
                   r, g, w0, exp);
        end
        n_checks++;
        if (best0 !== m_best || bf0 !== m_bf) begin
          n_fail++;
          $display("FAIL rnd_best_%0d_%0d: got %h/%0d want %h/%0d",
                   r, g, best0, bf0, m_best, m_bf);
        end
        n_checks++;
        if (gen0 !== m_gen || ces0 != 2) begin
          n_fail++;
          $display("FAIL rnd_gen_%0d_%0d: got %0d/%0d want %0d/2",
                   r, g, gen0, ces0, m_gen);
        end
      end
      @(negedge clk);
      n_checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0 || gen0 !== 16'd8) begin
        n_fail++;
        $display("FAIL rnd_done_%0d: got %b%b/%0d want 10/8",
                 r, done0, busy0, gen0);
      end
    end
    dly0 = 0;
  endtask

  task automatic test_full_run();
    int          mx = 0;
    int          pa, pb;
    int          gens = 0;
    logic [7:0]  wexp;
    logic [15:0] prev = '0;
    do_reset(1);
    start2 = 1'b1;
    for (int c = 0; c < 20000 && done2 !== 1'b1; c++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (b2.we) begin
        pa = $countones(s2a);
        pb = $countones(s2b);
        if (pa > mx) mx = pa;
        if (pb > mx) mx = pb;
        gens++;
        wexp = (pb > pa) ? s2b : s2a;
        n_checks++;
        if (b2.winner !== wexp) begin
          n_fail++;
          $display("FAIL full_winner_%0d: got %h want %h",
                   gens, b2.winner, wexp);
        end
        n_checks++;
        if (gen2 !== 16'(gens)) begin
          n_fail++;
          $display("FAIL full_gen: got %0d want %0d", gen2, gens);
        end
        n_checks++;
        if (bf2 < prev || bf2 !== 16'(mx)) begin
          n_fail++;
          $display("FAIL full_bf_%0d: got %0d want %0d (prev %0d)",
                   gens, bf2, mx, prev);
        end
        prev = bf2;
      end
    end
    n_checks++;
    if (done2 !== 1'b1 || gen2 !== 16'd200) begin
      n_fail++;
      $display("FAIL full_done: got %b/%0d want 1/200",
               done2, gen2);
    end
    n_checks++;
    if (bf2 < 16'd6 || 16'($countones(best2)) !== bf2) begin
      n_fail++;
      $display("FAIL full_best: got %h/%0d want >=6 popcount",
               best2, bf2);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_generation();
    test_tie_zero();
    test_handshake();
    test_back_to_back();
    test_abort();
    test_random();
    test_full_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
